// File: rtl/ehl_gpio_apb_if.sv
// APB3 bus bundle between a bus master and the GPIO register front-end.
interface ehl_gpio_apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ehl_gpio_apb.sv
// APB3 slave front-end for the GPIO core: turns each APB transfer into a single
// one-cycle register strobe, then returns read data and completion to the bus.
module ehl_gpio_apb #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    ehl_gpio_apb_if.slave    apb,
    output logic [10:0]      write_stb,
    output logic [10:0]      read_stb,
    output logic [10:0]      set_stb,
    output logic [10:0]      clr_stb,
    output logic [10:0]      inv_stb,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic        is_read;
    logic        is_err;
    logic [3:0]  idx;
    logic [1:0]  op;
    logic [10:0] onehot;
    logic        dec_err;
    logic [10:0] nxt_wr, nxt_rd, nxt_set, nxt_clr, nxt_inv;
    logic        unused_bits;

    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        zext = '0;
        zext[WIDTH-1:0] = v;
    endfunction

    // GIFR is write-1-to-clear, so its direct alias lands on the clear strobe.
    always_comb begin
        idx     = apb.paddr[5:2];
        op      = apb.paddr[7:6];
        onehot  = 11'd1 << idx;
        dec_err = (idx > 4'd10) ||
                  (apb.pwrite && ((idx == 4'd8) || ((idx == 4'd7) && op[0])));
        nxt_wr  = '0;
        nxt_rd  = '0;
        nxt_set = '0;
        nxt_clr = '0;
        nxt_inv = '0;
        if (!dec_err) begin
            if (!apb.pwrite) begin
                nxt_rd = onehot;
            end else begin
                case (op)
                    2'b00: begin
                        if (idx == 4'd7) nxt_clr = onehot;
                        else             nxt_wr  = onehot;
                    end
                    2'b01:   nxt_set = onehot;
                    2'b10:   nxt_clr = onehot;
                    default: nxt_inv = onehot;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            is_read     <= 1'b0;
            is_err      <= 1'b0;
            write_stb   <= '0;
            read_stb    <= '0;
            set_stb     <= '0;
            clr_stb     <= '0;
            inv_stb     <= '0;
            data_in     <= '0;
            apb.prdata  <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
        end else begin
            write_stb   <= '0;
            read_stb    <= '0;
            set_stb     <= '0;
            clr_stb     <= '0;
            inv_stb     <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        write_stb <= nxt_wr;
                        read_stb  <= nxt_rd;
                        set_stb   <= nxt_set;
                        clr_stb   <= nxt_clr;
                        inv_stb   <= nxt_inv;
                        data_in   <= apb.pwdata[WIDTH-1:0];
                        is_read   <= !apb.pwrite;
                        is_err    <= dec_err;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A master dropping psel mid-transfer abandons it silently.
                    if (!apb.psel) begin
                        state <= IDLE;
                    end else if (is_err || !is_read) begin
                        apb.pready  <= 1'b1;
                        apb.pslverr <= is_err;
                        if (is_err) apb.prdata <= '0;
                        state <= DONE;
                    end else if (RD_LATENCY == 0) begin
                        apb.prdata <= zext(data_out);
                        apb.pready <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!apb.psel) begin
                        state <= IDLE;
                    end else begin
                        apb.prdata <= zext(data_out);
                        apb.pready <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ehl_gpio_apb.sv
// Directed bench for ehl_gpio_apb: one DUT with combinational core read data
// (WIDTH 32, latency 0) and one with registered core read data (WIDTH 16, latency 1).
module tb_ehl_gpio_apb;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ehl_gpio_apb_if apb0();
    ehl_gpio_apb_if apb1();

    assign apb1.psel    = apb0.psel;
    assign apb1.penable = apb0.penable;
    assign apb1.pwrite  = apb0.pwrite;
    assign apb1.paddr   = apb0.paddr;
    assign apb1.pwdata  = apb0.pwdata;

    logic [10:0] wr0, rd0, set0, clr0, inv0;
    logic [10:0] wr1, rd1, set1, clr1, inv1;
    logic [31:0] din0, dout0;
    logic [15:0] din1;
    logic [15:0] dout1 = 16'hDEAD;
    logic [31:0] rd_val;

    // Core models: latency 0 answers combinationally, latency 1 one clock after the strobe.
    assign dout0 = (|rd0) ? rd_val : 32'hBAD0_BAD0;
    always @(posedge clk) dout1 <= (|rd1) ? rd_val[15:0] : 16'hDEAD;

    ehl_gpio_apb #(.WIDTH(32), .RD_LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .apb(apb0),
        .write_stb(wr0), .read_stb(rd0), .set_stb(set0), .clr_stb(clr0), .inv_stb(inv0),
        .data_in(din0), .data_out(dout0)
    );

    ehl_gpio_apb #(.WIDTH(16), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .apb(apb1),
        .write_stb(wr1), .read_stb(rd1), .set_stb(set1), .clr_stb(clr1), .inv_stb(inv1),
        .data_in(din1), .data_out(dout1)
    );

    logic [54:0] s   [2];
    logic        rdy [2];
    logic        err [2];
    logic [31:0] prd [2];
    logic [31:0] dinx[2];
    assign s[0]    = {inv0, clr0, set0, rd0, wr0};
    assign s[1]    = {inv1, clr1, set1, rd1, wr1};
    assign rdy[0]  = apb0.pready;
    assign rdy[1]  = apb1.pready;
    assign err[0]  = apb0.pslverr;
    assign err[1]  = apb1.pslverr;
    assign prd[0]  = apb0.prdata;
    assign prd[1]  = apb1.prdata;
    assign dinx[0] = din0;
    assign dinx[1] = {16'h0, din1};

    int          n_cmp = 0;
    int          n_mis = 0;
    int          rdy_cyc[2], rdy_cnt[2], stb_cyc[2], stb_first[2], stb_bits[2];
    logic [54:0] stb_vec[2];
    logic        err_at[2];
    logic [31:0] prd_at[2], din_at[2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [54:0] sb(input int kind, input int idx);
        sb = 55'd1 << (kind * 11 + idx);
    endfunction

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            rdy_cyc[d] = 0; rdy_cnt[d] = 0; stb_cyc[d] = 0; stb_first[d] = 0;
            stb_bits[d] = 0; stb_vec[d] = '0; err_at[d] = 1'b0;
            prd_at[d] = 32'hFFFF_FFFF; din_at[d] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic sample(input int k);
        for (int d = 0; d < 2; d++) begin
            if (s[d] != '0) begin
                stb_cyc[d]++;
                stb_bits[d] += $countones(s[d]);
                if (stb_first[d] == 0) begin
                    stb_first[d] = k; stb_vec[d] = s[d]; din_at[d] = dinx[d];
                end
            end
            if (rdy[d]) begin
                rdy_cnt[d]++;
                if (rdy_cyc[d] == 0) begin
                    rdy_cyc[d] = k; err_at[d] = err[d]; prd_at[d] = prd[d];
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with the bus idle.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rval);
        clear_obs();
        rd_val       = rval;
        apb0.psel    = 1'b1;
        apb0.penable = 1'b0;
        apb0.pwrite  = wr;
        apb0.paddr   = addr;
        apb0.pwdata  = wdata;
        @(posedge clk);
        #1;
        apb0.penable = 1'b1;
        apb0.pwrite  = ~wr;
        apb0.paddr   = ~addr;
        apb0.pwdata  = ~wdata;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sample(k);
            if (rdy_cyc[0] != 0 && rdy_cyc[1] != 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        apb0.psel    = 1'b0;
        apb0.penable = 1'b0;
    endtask

    task automatic watch(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            sample(k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input logic [54:0] exp_stb, input int exp_rdy1,
                          input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                          input logic [31:0] exp_din);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] m;
            m = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            check_eq($sformatf("%s/d%0d/stb", tag, d), 64'(stb_vec[d]), 64'(exp_stb));
            check_eq($sformatf("%s/d%0d/stb_cycles", tag, d), stb_cyc[d], (exp_stb != '0) ? 1 : 0);
            if (exp_stb != '0) begin
                check_eq($sformatf("%s/d%0d/stb_at", tag, d), stb_first[d], 1);
                check_eq($sformatf("%s/d%0d/stb_bits", tag, d), stb_bits[d], 1);
                check_eq($sformatf("%s/d%0d/data_in", tag, d), din_at[d], exp_din & m);
            end
            check_eq($sformatf("%s/d%0d/pready_at", tag, d), rdy_cyc[d], (d == 0) ? 2 : exp_rdy1);
            check_eq($sformatf("%s/d%0d/pready_cnt", tag, d), rdy_cnt[d], 1);
            check_eq($sformatf("%s/d%0d/pslverr", tag, d), err_at[d], exp_err);
            if (chk_rd) check_eq($sformatf("%s/d%0d/prdata", tag, d), prd_at[d], exp_rd & m);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        rd_val       = 32'h0;
        apb0.psel    = 1'b0;
        apb0.penable = 1'b0;
        apb0.pwrite  = 1'b0;
        apb0.paddr   = 8'h0;
        apb0.pwdata  = 32'h0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("reset/d%0d/stb", d), 64'(s[d]), 64'h0);
            check_eq($sformatf("reset/d%0d/pready", d), rdy[d], 1'b0);
            check_eq($sformatf("reset/d%0d/pslverr", d), err[d], 1'b0);
            check_eq($sformatf("reset/d%0d/prdata", d), prd[d], 32'h0);
            check_eq($sformatf("reset/d%0d/data_in", d), dinx[d], 32'h0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(1'b1, 8'h00, 32'h0000_00A5, 32'h0); verify("wr_gdor",    sb(0, 0), 2, 1'b0, 1'b0, 0, 32'hA5);
        xfer(1'b1, 8'h84, 32'h0000_000F, 32'h0); verify("clr_goer",   sb(3, 1), 2, 1'b0, 1'b0, 0, 32'h0F);
        xfer(1'b1, 8'h1C, 32'h0000_00FF, 32'h0); verify("w1c_gifr",   sb(3, 7), 2, 1'b0, 1'b0, 0, 32'hFF);
        xfer(1'b0, 8'h20, 32'h0, 32'h0000_1234); verify("rd_gdir",    sb(1, 8), 3, 1'b0, 1'b1, 32'h1234, 0);
        xfer(1'b1, 8'h20, 32'h0000_0011, 32'h0); verify("wr_gdir",    '0,       2, 1'b1, 1'b0, 0, 0);
        xfer(1'b1, 8'h2C, 32'h0000_0022, 32'h0); verify("wr_idx11",   '0,       2, 1'b1, 1'b0, 0, 0);
        xfer(1'b1, 8'h5C, 32'h0000_0033, 32'h0); verify("set_gifr",   '0,       2, 1'b1, 1'b0, 0, 0);
        xfer(1'b0, 8'h3C, 32'h0, 32'h0000_7777); verify("rd_idx15",   '0,       2, 1'b1, 1'b1, 32'h0, 0);
        xfer(1'b1, 8'h40, 32'h0000_0003, 32'h0); verify("b2b_set",    sb(2, 0), 2, 1'b0, 1'b0, 0, 32'h3);
        xfer(1'b0, 8'h00, 32'h0, 32'hCAFE_5A5A); verify("b2b_rd",     sb(1, 0), 3, 1'b0, 1'b1, 32'hCAFE_5A5A, 0);
        xfer(1'b1, 8'hC8, 32'h8000_0077, 32'h0); verify("inv_gafr",   sb(4, 2), 2, 1'b0, 1'b0, 0, 32'h8000_0077);
        xfer(1'b0, 8'h9C, 32'h0, 32'h0001_BEEF); verify("rd_clr_gifr",sb(1, 7), 3, 1'b0, 1'b1, 32'h0001_BEEF, 0);
        xfer(1'b1, 8'h28, 32'h0000_0001, 32'h0); verify("wr_gfmr",    sb(0, 10),2, 1'b0, 1'b0, 0, 32'h1);
        xfer(1'b1, 8'h07, 32'h0000_0042, 32'h0); verify("wr_goer_lsb",sb(0, 1), 2, 1'b0, 1'b0, 0, 32'h42);

        // Reset asserted while a read strobe is being issued.
        clear_obs();
        rd_val = 32'h0000_0099;
        apb0.psel = 1'b1; apb0.penable = 1'b0; apb0.pwrite = 1'b0; apb0.paddr = 8'h04;
        @(posedge clk);
        #1;
        apb0.penable = 1'b1;
        #2;
        check_eq("rst_issue/d0/stb_before", 64'(s[0]), 64'(sb(1, 1)));
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_issue/d%0d/stb", d), 64'(s[d]), 64'h0);
            check_eq($sformatf("rst_issue/d%0d/prdata", d), prd[d], 32'h0);
            check_eq($sformatf("rst_issue/d%0d/data_in", d), dinx[d], 32'h0);
        end
        apb0.psel = 1'b0; apb0.penable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        watch(3);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_issue/d%0d/pready_after", d), rdy_cnt[d], 0);
            check_eq($sformatf("rst_issue/d%0d/stb_after", d), stb_cyc[d], 0);
        end
        xfer(1'b0, 8'h0C, 32'h0, 32'h0000_4321); verify("after_rst", sb(1, 3), 3, 1'b0, 1'b1, 32'h4321, 0);

        // psel dropped while the latency-1 DUT waits for read data.
        clear_obs();
        rd_val = 32'h0000_000C;
        apb0.psel = 1'b1; apb0.penable = 1'b0; apb0.pwrite = 1'b0; apb0.paddr = 8'h18;
        @(posedge clk);
        #1;
        apb0.penable = 1'b1;
        @(posedge clk);
        #1;
        apb0.psel = 1'b0; apb0.penable = 1'b0;
        watch(4);
        check_eq("drop_wait/d1/pready", rdy_cnt[1], 0);
        check_eq("drop_wait/d1/stb", stb_cyc[1], 0);
        check_eq("drop_wait/d0/pready", rdy_cnt[0], 1);
        xfer(1'b1, 8'h14, 32'h0000_0005, 32'h0); verify("after_drop_wait", sb(0, 5), 2, 1'b0, 1'b0, 0, 32'h5);

        // psel dropped during the strobe cycle itself.
        clear_obs();
        apb0.psel = 1'b1; apb0.penable = 1'b0; apb0.pwrite = 1'b1; apb0.paddr = 8'h10;
        apb0.pwdata = 32'h0000_0006;
        @(posedge clk);
        #1;
        apb0.psel = 1'b0; apb0.penable = 1'b0;
        watch(4);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("drop_issue/d%0d/stb", d), 64'(stb_vec[d]), 64'(sb(0, 4)));
            check_eq($sformatf("drop_issue/d%0d/stb_cycles", d), stb_cyc[d], 1);
            check_eq($sformatf("drop_issue/d%0d/pready", d), rdy_cnt[d], 0);
        end
        xfer(1'b0, 8'h24, 32'h0, 32'h0000_0A0A); verify("after_drop_issue", sb(1, 9), 3, 1'b0, 1'b1, 32'h0A0A, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/ehl_gpio_apb.md
Name: ehl_gpio_apb

Overview:
- APB3 slave front-end for the GPIO core; bus-side initiator of the core's register strobe interface.
- Decodes APB transfers into one-cycle write/read/set/clr/inv strobes plus write data.
- Waits the core's read-data latency, captures data_out into prdata, and completes the handshake with pready/pslverr.

Parameters:
- WIDTH, 32: GPIO width, 1..32; prdata bits above WIDTH read 0.
- RD_LATENCY, 0: core data_out latency in clk cycles after read strobe, 0 or 1; matches core REGISTERED_OUTPUT.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write
- paddr  in  8  byte address; [1:0] ignored
- pwdata  in  32  write data
- prdata  out  32  read data, valid with pready
- pready  out  1  transfer complete
- pslverr  out  1  error, valid with pready
- write_stb  out  11  one-hot direct-write strobe, bit = register index
- read_stb  out  11  one-hot read strobe
- set_stb  out  11  one-hot set strobe; integration forms set_x = {WIDTH{set_stb[i]}} & data_in
- clr_stb  out  11  one-hot clear strobe, same scheme
- inv_stb  out  11  one-hot invert strobe, same scheme
- data_in  out  WIDTH  registered pwdata[WIDTH-1:0] for core
- data_out  in  WIDTH  core read mux

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE.
- Register index (paddr[5:2]):
  - 0 GDOR, 1 GOER, 2 GAFR, 3 GPER, 4 GPTR, 5 GIER, 6 GISR, 7 GIFR, 8 GDIR, 9 GCMR, 10 GFMR.
  - 11..15 unmapped.
- Operation (paddr[7:6]): 00 direct, 01 set, 10 clr, 11 inv.
- Reads: any op alias reads the register; read_stb[idx] pulses once.
- Writes:
  - Direct write pulses write_stb; aliases pulse set_stb, clr_stb or inv_stb.
  - GIFR: clr alias pulses clr_stb[7]; a direct write to GIFR also maps to clr_stb[7] (W1C).
  - GIFR set/inv writes are errors. Any GDIR write is an error.
- Errors: unmapped index or illegal write gives pslverr=1 with pready. No strobe issued, prdata=0.
- FSM states IDLE, ISSUE, WAIT, DONE:
  - IDLE: psel & !penable latches paddr/pwrite/pwdata, decodes; -> ISSUE.
  - ISSUE (1 cycle): the selected strobe is high for exactly this cycle; data_in valid this cycle.
  - ISSUE exit: write or error -> DONE. Read with RD_LATENCY=0 captures data_out -> DONE. Read with RD_LATENCY=1 -> WAIT.
  - WAIT (1 cycle): captures data_out -> DONE.
  - DONE: pready=1 (registered) and pslverr; -> IDLE. prdata holds until the next read capture.
- Latency from the setup cycle to the pready cycle:
  - writes/errors: 2 cycles;
  - reads: 2+RD_LATENCY cycles.
  - penable is high in every cycle after setup.
- Exactly one strobe bit across all five vectors per transfer; never more than one cycle.
- Back-to-back: a new setup in the cycle after DONE is accepted; no idle cycle is required.
- psel low in ISSUE/WAIT (protocol violation): abort to IDLE. Strobes already issued are not repeated; no pready.
- pwrite/paddr changes after setup are ignored; latched values are used.
- Reset mid-transfer: immediate return to IDLE, outputs 0, no pready.

Test Plan:
- Write 0x0000_00A5 to 0x00 (GDOR direct) -> write_stb=0x001 for one cycle, data_in=0xA5, pready at setup+2, pslverr=0.
- Write 0x0F to 0x84 (clr GOER) -> clr_stb=0x002 one cycle, data_in=0x0F; write to 0x1C (GIFR direct) -> clr_stb=0x080.
- RD_LATENCY=1, read 0x20 (GDIR) with data_out=0x1234 -> read_stb=0x100 one cycle, pready at setup+3, prdata=0x1234; with RD_LATENCY=0, pready at setup+2.
- Write to 0x20 (GDIR), to 0x2C (index 11), and 0x5C (set GIFR) -> each: no strobes, pready at setup+2, pslverr=1; read 0x3C -> pslverr=1, prdata=0.
- Back-to-back write 0x40 (set GDOR) then read 0x00 -> set_stb=0x001, then read_stb=0x001; each transfer has one pready, no lost or duplicated strobe.
- reset_n low during ISSUE of a read, or psel dropped in WAIT -> no pready, all strobes 0 next cycle, FSM IDLE, next transfer normal.
